// File: rtl/full_adder_bit.sv
// Purely combinational 1-bit full-adder slice: s = a ^ b ^ cin, majority carry out.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder, {carry_out, sum} = a + b + carry_in.
// Latency 1 cycle; accepts one operand set per cycle, never stalls.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = carry_in;

  // Carry ripples LSB to MSB; this chain is the critical path.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    full_adder_bit u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum_comb[i]),
      .cout (carry[i+1])
    );
  end

  // Result registers load only on valid, so inputs are don't-care otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= sum_comb;
        carry_out <= carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: 1-bit and 4-bit instances against an arithmetic reference model.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst;

  logic       v1, a1, b1, c1;
  logic       s1, co1, ov1;

  logic       v4, c4;
  logic [3:0] a4, b4;
  logic [3:0] s4;
  logic       co4, ov4;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .carry_in(c1),
    .sum(s1), .carry_out(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .carry_in(c4),
    .sum(s4), .carry_out(co4), .out_valid(ov4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Apply current inputs at the next rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ref_val;
    int ea, eb, ec;

    // Reset takes priority over a valid operand set.
    rst = 1'b1;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    tick();
    chk("rst_sum1", {31'd0, s1}, 0);
    chk("rst_co1",  {31'd0, co1}, 0);
    chk("rst_ov1",  {31'd0, ov1}, 0);
    chk("rst_sum4", {28'd0, s4}, 0);
    chk("rst_co4",  {31'd0, co4}, 0);
    chk("rst_ov4",  {31'd0, ov4}, 0);

    // Exhaustive 1-bit; 4-bit instance idles and must hold zero.
    rst = 1'b0;
    v4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ea = (i >> 2) & 1; eb = (i >> 1) & 1; ec = i & 1;
      v1 = 1'b1; a1 = ea[0]; b1 = eb[0]; c1 = ec[0];
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      tick();
      ref_val = ea + eb + ec;
      chk($sformatf("w1_sum_%0d", i), {31'd0, s1},  ref_val % 2);
      chk($sformatf("w1_co_%0d", i),  {31'd0, co1}, ref_val / 2);
      chk($sformatf("w1_ov_%0d", i),  {31'd0, ov1}, 1);
      chk($sformatf("w4_idle_ov_%0d", i), {31'd0, ov4}, 0);
      chk($sformatf("w4_idle_sum_%0d", i), {27'd0, co4, s4}, 0);
    end

    // Hold last 111 result while invalid inputs toggle, including X.
    v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a1 = (i == 1) ? 1'bx : 1'(i); b1 = ~a1; c1 = (i == 2) ? 1'bx : 1'b0;
      tick();
      chk($sformatf("hold_sum_%0d", i), {31'd0, s1},  1);
      chk($sformatf("hold_co_%0d", i),  {31'd0, co1}, 1);
      chk($sformatf("hold_ov_%0d", i),  {31'd0, ov1}, 0);
    end

    // Full carry ripple through all four slices.
    v4 = 1'b1; a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    tick();
    chk("ripple_f0_sum", {28'd0, s4}, 0);
    chk("ripple_f0_co",  {31'd0, co4}, 1);
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    tick();
    chk("wrap_ff_sum", {28'd0, s4}, 15);
    chk("wrap_ff_co",  {31'd0, co4}, 1);

    // Back-to-back random stream.
    for (int i = 0; i < 200; i++) begin
      ea = int'($urandom_range(15)); eb = int'($urandom_range(15)); ec = int'($urandom_range(1));
      a4 = 4'(ea); b4 = 4'(eb); c4 = ec[0];
      tick();
      ref_val = ea + eb + ec;
      chk($sformatf("rnd_%0d", i), {27'd0, co4, s4}, ref_val);
      chk($sformatf("rnd_ov_%0d", i), {31'd0, ov4}, 1);
    end

    // Mid-stream reset with valid operands present.
    rst = 1'b1;
    a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'b1;
    tick();
    chk("mid_rst_val", {27'd0, co4, s4}, 0);
    chk("mid_rst_ov",  {31'd0, ov4}, 0);
    rst = 1'b0;
    ea = int'($urandom_range(15)); eb = int'($urandom_range(15)); ec = int'($urandom_range(1));
    a4 = 4'(ea); b4 = 4'(eb); c4 = ec[0];
    tick();
    chk("post_rst_val", {27'd0, co4, s4}, ea + eb + ec);
    chk("post_rst_ov",  {31'd0, ov4}, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
